// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the ID-stage decode and the hazard controller.
// The master side (ID stage / pipeline control) drives the decoded fields and the
// EX branch outcome; the slave side (hazard_ctrl_unit) returns stall/flush/bubble
// controls, the registered forwarding selects and statistics.
interface hazard_ctrl_if #(
    parameter int NUM_FWD_STAGES = 2,
    parameter int REG_ADDR_W     = 5
);
    localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_rd_wr;
    logic                  id_is_load;
    logic                  ex_br_taken;

    logic                  stall_if_id;
    logic                  bubble_ex;
    logic                  flush_if_id;
    logic [SEL_W-1:0]      fwd_sel_a;
    logic [SEL_W-1:0]      fwd_sel_b;
    logic                  busy;
    logic [31:0]           stall_count;
    logic [31:0]           flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_wr, id_is_load, ex_br_taken,
        input  stall_if_id, bubble_ex, flush_if_id, fwd_sel_a, fwd_sel_b,
               busy, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_wr, id_is_load, ex_br_taken,
        output stall_if_id, bubble_ex, flush_if_id, fwd_sel_a, fwd_sel_b,
               busy, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: parametrised hazard controller for the pipelined RV32I core.
// Tracks in-flight destination registers from EX onward in a shift-register
// scoreboard, produces registered forwarding selects for the instruction entering
// EX, stalls on load-use hazards and holds a counted front-end flush after a
// taken branch. Priority is flush > stall > issue.
// Optional feature: define HAZARD_STATS_EN to build the saturating stall/flush
// cycle counters; without it stall_count and flush_count are tied to zero.
module hazard_ctrl_unit #(
    parameter int NUM_FWD_STAGES = 2,
    parameter int LOAD_LAT       = 1,
    parameter int FLUSH_DEPTH    = 2,
    parameter int REG_ADDR_W     = 5
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);
    localparam int FC_W  = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Youngest-wins lookup over the per-entry hit vector. Returns {load_use, sel}:
    // sel = j+1 for the lowest matching entry j, load_use when that entry is a
    // load whose data is not yet forwardable.
    function automatic logic [SEL_W:0] youngest_hit(
        input logic [NUM_FWD_STAGES-1:0] hits,
        input logic [NUM_FWD_STAGES-1:0] loads
    );
        logic [SEL_W-1:0] sel;
        logic             lu;
        sel = {SEL_W{1'b0}};
        lu  = 1'b0;
        for (int j = NUM_FWD_STAGES - 1; j >= 0; j--) begin
            sel = hits[j] ? SEL_W'(j + 1) : sel;
            lu  = hits[j] ? (loads[j] & (j < LOAD_LAT)) : lu;
        end
        return {lu, sel};
    endfunction

    // Scoreboard: entry 0 is the instruction in EX, entry j is j stages after EX.
    logic [NUM_FWD_STAGES-1:0] sb_valid_r;
    logic [NUM_FWD_STAGES-1:0] sb_wr_r;
    logic [NUM_FWD_STAGES-1:0] sb_load_r;
    logic [REG_ADDR_W-1:0]     sb_rd_r [NUM_FWD_STAGES];

    logic [FC_W-1:0]           flush_cnt_r;
    logic [FC_W-1:0]           flush_cnt_nxt_s;
    logic [1:0]                state_r;
    logic [1:0]                state_nxt_s;
    logic [SEL_W-1:0]          fwd_sel_a_r;
    logic [SEL_W-1:0]          fwd_sel_b_r;

    logic [NUM_FWD_STAGES-1:0] hit_a_s;
    logic [NUM_FWD_STAGES-1:0] hit_b_s;
    logic [SEL_W:0]            look_a_s;
    logic [SEL_W:0]            look_b_s;
    logic [SEL_W-1:0]          sel_a_s;
    logic [SEL_W-1:0]          sel_b_s;
    logic                      load_use_s;
    logic                      flush_active_s;
    logic                      stall_s;
    logic                      bubble_s;
    logic                      issue_s;

    // Compare each ID source against every scoreboard entry; x0 and unread sources never match.
    always_comb begin
        hit_a_s = {NUM_FWD_STAGES{1'b0}};
        hit_b_s = {NUM_FWD_STAGES{1'b0}};
        for (int j = 0; j < NUM_FWD_STAGES; j++) begin
            hit_a_s[j] = sb_valid_r[j] & sb_wr_r[j] & (sb_rd_r[j] == hz.id_rs1)
                       & (hz.id_rs1 != {REG_ADDR_W{1'b0}}) & hz.id_rs1_used;
            hit_b_s[j] = sb_valid_r[j] & sb_wr_r[j] & (sb_rd_r[j] == hz.id_rs2)
                       & (hz.id_rs2 != {REG_ADDR_W{1'b0}}) & hz.id_rs2_used;
        end
    end

    assign look_a_s = youngest_hit(hit_a_s, sb_load_r);
    assign look_b_s = youngest_hit(hit_b_s, sb_load_r);
    assign sel_a_s  = look_a_s[SEL_W-1:0];
    assign sel_b_s  = look_b_s[SEL_W-1:0];

    // Resolve the cycle's action: flush beats a load-use stall, which beats issue.
    always_comb begin
        flush_active_s = hz.ex_br_taken | (flush_cnt_r != {FC_W{1'b0}});
        load_use_s     = hz.id_valid & (look_a_s[SEL_W] | look_b_s[SEL_W]);
        stall_s        = load_use_s & ~flush_active_s;
        bubble_s       = flush_active_s | load_use_s;
        issue_s        = hz.id_valid & ~flush_active_s & ~load_use_s;
    end

    // Flush counter: a taken branch (re)loads it, otherwise it counts down to zero.
    always_comb begin
        flush_cnt_nxt_s = flush_cnt_r;
        if (hz.ex_br_taken) begin
            flush_cnt_nxt_s = FC_W'(FLUSH_DEPTH - 1);
        end else if (flush_cnt_r != {FC_W{1'b0}}) begin
            flush_cnt_nxt_s = flush_cnt_r - {{(FC_W-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_nxt_s = {FC_W{1'b0}};
        end
    end

    // Controller FSM next state; FLUSH always returns through IDLE before any stall.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE, ST_STALL: begin
                if (hz.ex_br_taken) begin
                    state_nxt_s = ST_FLUSH;
                end else if (load_use_s) begin
                    state_nxt_s = ST_STALL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (hz.ex_br_taken || (flush_cnt_nxt_s != {FC_W{1'b0}})) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Scoreboard shift: insert the issuing ID instruction (or a bubble), age the rest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_valid_r <= {NUM_FWD_STAGES{1'b0}};
            sb_wr_r    <= {NUM_FWD_STAGES{1'b0}};
            sb_load_r  <= {NUM_FWD_STAGES{1'b0}};
            for (int j = 0; j < NUM_FWD_STAGES; j++) begin
                sb_rd_r[j] <= {REG_ADDR_W{1'b0}};
            end
        end else begin
            sb_valid_r[0] <= issue_s;
            sb_wr_r[0]    <= hz.id_rd_wr;
            sb_load_r[0]  <= hz.id_is_load;
            sb_rd_r[0]    <= hz.id_rd;
            for (int j = 1; j < NUM_FWD_STAGES; j++) begin
                sb_valid_r[j] <= sb_valid_r[j-1];
                sb_wr_r[j]    <= sb_wr_r[j-1];
                sb_load_r[j]  <= sb_load_r[j-1];
                sb_rd_r[j]    <= sb_rd_r[j-1];
            end
        end
    end

    // Control state: FSM, flush counter and the forwarding selects for the next EX occupant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            flush_cnt_r <= {FC_W{1'b0}};
            fwd_sel_a_r <= {SEL_W{1'b0}};
            fwd_sel_b_r <= {SEL_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
            fwd_sel_a_r <= issue_s ? sel_a_s : {SEL_W{1'b0}};
            fwd_sel_b_r <= issue_s ? sel_b_s : {SEL_W{1'b0}};
        end
    end

    assign hz.stall_if_id = stall_s;
    assign hz.bubble_ex   = bubble_s;
    assign hz.flush_if_id = flush_active_s;
    assign hz.fwd_sel_a   = fwd_sel_a_r;
    assign hz.fwd_sel_b   = fwd_sel_b_r;
    assign hz.busy        = (state_r != ST_IDLE);

`ifdef HAZARD_STATS_EN
    // Saturating increment so long runs pin at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
    endfunction

    logic [31:0] stall_count_r;
    logic [31:0] flush_count_r;

    // Cycle counters for stall and flush activity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_r <= 32'd0;
            flush_count_r <= 32'd0;
        end else begin
            stall_count_r <= sat_inc(stall_count_r, stall_s);
            flush_count_r <= sat_inc(flush_count_r, flush_active_s);
        end
    end

    assign hz.stall_count = stall_count_r;
    assign hz.flush_count = flush_count_r;
`else
    assign hz.stall_count = 32'd0;
    assign hz.flush_count = 32'd0;
`endif

endmodule
